memory_game_fsm: RTL and testbench

Game-control stage of the 4×4 memory game, directly upstream of the VGA block renderer. It generates a pseudo-random 16-cell pattern, flashes it for a fixed time, then tracks cursor movement and player guesses. It decides win or loss and drives the one-hot game state. All outputs are registered and feed the renderer's `X/Y`, `A0..A3`, `B0..B3` and `Qi/Qfo/Qp/Qg/Ql` inputs unchanged.

---
 rtl/memory_game_pkg.sv | 39 +++
 rtl/memory_game_fsm_lfsr16.sv | 29 ++
 rtl/memory_game_fsm.sv | 164 ++++++++++++++++
 tb/tb_memory_game_fsm.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the 4x4 memory game control slice.
package memory_game_pkg;

    localparam int          GRID              = 4;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FLASH = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Bit order matches the renderer: {Ql, Qg, Qp, Qfo, Qi}.
    function automatic logic [4:0] stateOneHot(input state_e s);
        logic [4:0] oh;
        case (s)
            ST_INIT:  oh = 5'b00001;
            ST_FLASH: oh = 5'b00010;
            ST_PLAY:  oh = 5'b00100;
            ST_WIN:   oh = 5'b01000;
            ST_LOSE:  oh = 5'b10000;
            default:  oh = 5'b00001;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/memory_game_fsm_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); never reaches zero from a non-zero seed.
module lfsr16
    import memory_game_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/memory_game_fsm.sv
// Memory game controller: pattern capture, timed flash, cursor/guess tracking and win/lose decision.
module memory_game_fsm
    import memory_game_pkg::*;
#(
    parameter int          SHOW_CYCLES = 100_000_000,
    parameter logic [15:0] LFSR_SEED   = LFSR_DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       BtnC,
    output logic [1:0] X,
    output logic [1:0] Y,
    output logic [3:0] A0,
    output logic [3:0] A1,
    output logic [3:0] A2,
    output logic [3:0] A3,
    output logic [3:0] B0,
    output logic [3:0] B1,
    output logic [3:0] B2,
    output logic [3:0] B3,
    output logic       Qi,
    output logic       Qfo,
    output logic       Qp,
    output logic       Qg,
    output logic       Ql
);

    localparam int            TW         = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(SHOW_CYCLES - 1);

    state_e                          state_q, state_d;
    logic [4:0]                      onehot_q, onehot_d;
    logic [1:0]                      x_q, x_d;
    logic [1:0]                      y_q, y_d;
    logic [GRID-1:0][GRID-1:0]       a_q, a_d;
    logic [GRID-1:0][GRID-1:0]       b_q, b_d;
    logic [4:0]                      hits_q, hits_d;
    logic [4:0]                      target_q, target_d;
    logic [TW-1:0]                   timer_q, timer_d;
    logic [15:0]                     lfsrValue;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .value_o (lfsrValue)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        a_d      = a_q;
        b_d      = b_q;
        hits_d   = hits_q;
        target_d = target_q;
        timer_d  = timer_q;

        case (state_q)
            ST_INIT: begin
                if (BtnC) begin
                    a_d      = lfsrValue;
                    target_d = popcount16(lfsrValue);
                    state_d  = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    state_d = ST_PLAY;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_PLAY: begin
                // Guess outranks movement; the chosen cell's B bit lands together with any terminal state.
                if (BtnC) begin
                    if (!b_q[x_q][y_q]) begin
                        b_d[x_q][y_q] = 1'b1;
                        if (!a_q[x_q][y_q]) begin
                            state_d = ST_LOSE;
                        end else begin
                            hits_d = (hits_q == 5'd16) ? hits_q : hits_q + 5'd1;
                            if ((hits_q + 5'd1) == target_q) begin
                                state_d = ST_WIN;
                            end
                        end
                    end
                end else if (BtnU) begin
                    x_d = x_q - 2'd1;
                end else if (BtnD) begin
                    x_d = x_q + 2'd1;
                end else if (BtnL) begin
                    y_d = y_q - 2'd1;
                end else if (BtnR) begin
                    y_d = y_q + 2'd1;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (BtnC) begin
                    x_d      = '0;
                    y_d      = '0;
                    a_d      = '0;
                    b_d      = '0;
                    hits_d   = '0;
                    target_d = '0;
                    timer_d  = '0;
                    state_d  = ST_INIT;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        onehot_d = stateOneHot(state_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_INIT;
            onehot_q <= 5'b00001;
            x_q      <= '0;
            y_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hits_q   <= '0;
            target_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            x_q      <= x_d;
            y_q      <= y_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hits_q   <= hits_d;
            target_q <= target_d;
            timer_q  <= timer_d;
        end
    end

    assign X   = x_q;
    assign Y   = y_q;
    assign A0  = a_q[0];
    assign A1  = a_q[1];
    assign A2  = a_q[2];
    assign A3  = a_q[3];
    assign B0  = b_q[0];
    assign B1  = b_q[1];
    assign B2  = b_q[2];
    assign B3  = b_q[3];
    assign Qi  = onehot_q[0];
    assign Qfo = onehot_q[1];
    assign Qp  = onehot_q[2];
    assign Qg  = onehot_q[3];
    assign Ql  = onehot_q[4];

endmodule

// File: tb/tb_memory_game_fsm.sv
// Scoreboard bench for memory_game_fsm: directed button vectors queue their expected snapshots for a monitor.
module tb_memory_game_fsm;

    localparam logic [4:0] BN = 5'b00000;
    localparam logic [4:0] BC = 5'b10000;
    localparam logic [4:0] BU = 5'b01000;
    localparam logic [4:0] BD = 5'b00100;
    localparam logic [4:0] BL = 5'b00010;
    localparam logic [4:0] BR = 5'b00001;

    localparam logic [4:0] QI = 5'b00001;
    localparam logic [4:0] QF = 5'b00010;
    localparam logic [4:0] QP = 5'b00100;
    localparam logic [4:0] QG = 5'b01000;
    localparam logic [4:0] QL = 5'b10000;

    typedef struct packed {
        logic [1:0]  x;
        logic [1:0]  y;
        logic [15:0] a;
        logic [15:0] b;
        logic [4:0]  q;
    } snap_t;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic BtnU = 1'b0;
    logic BtnD = 1'b0;
    logic BtnL = 1'b0;
    logic BtnR = 1'b0;
    logic BtnC = 1'b0;
    logic [1:0] X, Y;
    logic [3:0] A0, A1, A2, A3, B0, B1, B2, B3;
    logic Qi, Qfo, Qp, Qg, Ql;

    logic [1:0]  eX = '0;
    logic [1:0]  eY = '0;
    logic [15:0] eA = '0;
    logic [15:0] eB = '0;
    logic [4:0]  eQ = QI;

    snap_t expQ[$];
    string nameQ[$];
    int    checks   = 0;
    int    failures = 0;
    event  asyncEv;

    memory_game_fsm #(
        .SHOW_CYCLES (4),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .BtnU (BtnU),
        .BtnD (BtnD),
        .BtnL (BtnL),
        .BtnR (BtnR),
        .BtnC (BtnC),
        .X    (X),
        .Y    (Y),
        .A0   (A0),
        .A1   (A1),
        .A2   (A2),
        .A3   (A3),
        .B0   (B0),
        .B1   (B1),
        .B2   (B2),
        .B3   (B3),
        .Qi   (Qi),
        .Qfo  (Qfo),
        .Qp   (Qp),
        .Qg   (Qg),
        .Ql   (Ql)
    );

    always #5 clk = ~clk;

    // Queue the snapshot expected after the next active edge while the buttons are held for that edge.
    task automatic applyStimulus(input logic [4:0] btn, input logic rstVal, input string nm);
        snap_t s;
        @(negedge clk);
        rst = rstVal;
        {BtnC, BtnU, BtnD, BtnL, BtnR} = btn;
        s.x = eX;
        s.y = eY;
        s.a = eA;
        s.b = eB;
        s.q = eQ;
        expQ.push_back(s);
        nameQ.push_back(nm);
    endtask

    task automatic asyncReset(input string nm);
        snap_t s;
        @(negedge clk);
        {BtnC, BtnU, BtnD, BtnL, BtnR} = BN;
        #2;
        rst = 1'b1;
        eX = '0; eY = '0; eA = '0; eB = '0; eQ = QI;
        s.x = eX;
        s.y = eY;
        s.a = eA;
        s.b = eB;
        s.q = eQ;
        expQ.push_back(s);
        nameQ.push_back(nm);
        ->asyncEv;
    endtask

    task automatic startGame();
        eX = '0; eY = '0; eA = '0; eB = '0; eQ = QI;
        applyStimulus(BN, 1'b1, "reset_hold");
        eA = 16'hACE1; eQ = QF;
        applyStimulus(BC, 1'b0, "capture_seed");
        applyStimulus(BC, 1'b0, "flash_ignores_c");
        applyStimulus(BU, 1'b0, "flash_ignores_u");
        applyStimulus(BR, 1'b0, "flash_ignores_r");
        eQ = QP;
        applyStimulus(BL, 1'b0, "flash_to_play");
    endtask

    task automatic checkOutput();
        snap_t exp, act;
        string nm;
        exp = expQ.pop_front();
        nm  = nameQ.pop_front();
        act.x = X;
        act.y = Y;
        act.a = {A3, A2, A1, A0};
        act.b = {B3, B2, B1, B0};
        act.q = {Ql, Qg, Qp, Qfo, Qi};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got X=%0d Y=%0d A=%h B=%h Q=%b, expected X=%0d Y=%0d A=%h B=%h Q=%b",
                     nm, act.x, act.y, act.a, act.b, act.q, exp.x, exp.y, exp.a, exp.b, exp.q);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or asyncEv);
            #1;
            if (expQ.size() > 0) begin
                checkOutput();
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Game 1: cursor wrapping, priority, duplicate guess, full win.
        startGame();
        eX = 2'd3; applyStimulus(BU, 1'b0, "x_up_wrap");
        eX = 2'd0; applyStimulus(BD, 1'b0, "x_down_wrap");
        eY = 2'd3; applyStimulus(BL, 1'b0, "y_left_wrap");
        eY = 2'd0; applyStimulus(BR, 1'b0, "y_right_wrap");
        for (int i = 0; i < 4; i++) begin
            eY = eY + 2'd1;
            applyStimulus(BR, 1'b0, "y_right_walk");
        end
        eX = 2'd1; applyStimulus(BD | BL, 1'b0, "prio_down_over_left");
        eX = 2'd0; applyStimulus(BU, 1'b0, "x_up");
        eB = 16'h0001; applyStimulus(BU | BC, 1'b0, "prio_guess_over_up");
        applyStimulus(BC, 1'b0, "repeat_guess_ignored");
        eX = 2'd1; applyStimulus(BD, 1'b0, "mv_1_0");
        eY = 2'd1; applyStimulus(BR, 1'b0, "mv_1_1");
        eB = 16'h0021; applyStimulus(BC, 1'b0, "hit_1_1");
        eY = 2'd2; applyStimulus(BR, 1'b0, "mv_1_2");
        eB = 16'h0061; applyStimulus(BC, 1'b0, "hit_1_2");
        eY = 2'd3; applyStimulus(BR, 1'b0, "mv_1_3");
        eB = 16'h00E1; applyStimulus(BC, 1'b0, "hit_1_3");
        eX = 2'd2; applyStimulus(BD, 1'b0, "mv_2_3");
        eB = 16'h08E1; applyStimulus(BC, 1'b0, "hit_2_3");
        eY = 2'd2; applyStimulus(BL, 1'b0, "mv_2_2");
        eB = 16'h0CE1; applyStimulus(BC, 1'b0, "hit_2_2");
        eX = 2'd3; applyStimulus(BD, 1'b0, "mv_3_2");
        eY = 2'd1; applyStimulus(BL, 1'b0, "mv_3_1");
        eB = 16'h2CE1; applyStimulus(BC, 1'b0, "hit_3_1");
        eY = 2'd2; applyStimulus(BR, 1'b0, "mv_3_2b");
        eY = 2'd3; applyStimulus(BR, 1'b0, "mv_3_3");
        eB = 16'hACE1; eQ = QG; applyStimulus(BC, 1'b0, "win_8th_hit");
        applyStimulus(BU, 1'b0, "win_ignores_up");
        eX = '0; eY = '0; eA = '0; eB = '0; eQ = QI;
        applyStimulus(BC, 1'b0, "win_to_init");

        // Game 2: one hit then a miss.
        startGame();
        eB = 16'h0001; applyStimulus(BC, 1'b0, "hit_0_0");
        eY = 2'd1; applyStimulus(BR, 1'b0, "mv_0_1");
        eB = 16'h0003; eQ = QL; applyStimulus(BC, 1'b0, "miss_0_1_lose");
        applyStimulus(BD, 1'b0, "lose_ignores_down");
        eX = '0; eY = '0; eA = '0; eB = '0; eQ = QI;
        applyStimulus(BC, 1'b0, "lose_to_init");

        // Game 3: asynchronous reset mid-play, then LFSR restart.
        startGame();
        eX = 2'd1; applyStimulus(BD, 1'b0, "mv_1_0");
        eY = 2'd1; applyStimulus(BR, 1'b0, "mv_1_1");
        eB = 16'h0020; applyStimulus(BC, 1'b0, "hit_1_1");
        asyncReset("async_reset_midplay");
        applyStimulus(BN, 1'b0, "release_reset");
        eA = 16'h59C3; eQ = QF;
        applyStimulus(BC, 1'b0, "capture_second_lfsr");
        applyStimulus(BN, 1'b0, "flash_after_restart");

        @(negedge clk);
        {BtnC, BtnU, BtnD, BtnL, BtnR} = BN;
        @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
